// File: rtl/flit_reassembler_if.sv
// Flit-in / packet-out bundle for flit_reassembler.
// The master drives flits and the packet ready; the slave is the reassembler.
interface flit_reassembler_if #(
    parameter int MAX_FLITS  = 8,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH+1:0]           flit_in;
    logic                            flit_valid;
    logic                            flit_ready;
    logic                            pkt_valid;
    logic                            pkt_ready;
    logic [7:0]                      pkt_src;
    logic [7:0]                      pkt_dst;
    logic [7:0]                      pkt_id;
    logic [3:0]                      pkt_len;
    logic [MAX_FLITS*DATA_WIDTH-1:0] pkt_payload;
    logic                            err_pulse;
    logic [7:0]                      err_count;

    modport master (
        output flit_in, flit_valid, pkt_ready,
        input  flit_ready, pkt_valid, pkt_src, pkt_dst, pkt_id, pkt_len,
        input  pkt_payload, err_pulse, err_count
    );

    modport slave (
        input  flit_in, flit_valid, pkt_ready,
        output flit_ready, pkt_valid, pkt_src, pkt_dst, pkt_id, pkt_len,
        output pkt_payload, err_pulse, err_count
    );
endinterface

// File: rtl/flit_reassembler.sv
// Collects HEAD/BODY/TAIL flits into one packet and holds it until the consumer takes it.
// Protocol violations are counted (saturating) and reported with a one-cycle pulse.
module flit_reassembler #(
    parameter int MAX_FLITS  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    flit_reassembler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam logic [1:0] T_HEAD = 2'd0;
    localparam logic [1:0] T_BODY = 2'd1;
    localparam logic [1:0] T_TAIL = 2'd2;
    localparam logic [4:0] MAX_LEN = 5'(MAX_FLITS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_src;
    logic [7:0]            r_dst;
    logic [7:0]            r_id;
    logic [3:0]            r_len;
    logic [3:0]            r_count;
    logic [DATA_WIDTH-1:0] r_words [MAX_FLITS];
    logic                  r_err_pulse;
    logic [7:0]            r_err_count;

    logic [1:0]            w_type;
    logic [DATA_WIDTH-1:0] w_data;
    logic [3:0]            w_hd_len;
    logic                  w_hd_ok;
    logic                  w_accept;
    logic [4:0]            w_cnt_inc;
    logic                  w_latch;
    logic                  w_store;
    logic                  w_err;

    assign w_type    = bus.flit_in[DATA_WIDTH+1:DATA_WIDTH];
    assign w_data    = bus.flit_in[DATA_WIDTH-1:0];
    assign w_hd_len  = w_data[7:4];
    assign w_hd_ok   = (w_hd_len != 4'd0) && ({1'b0, w_hd_len} <= MAX_LEN);
    assign w_accept  = bus.flit_valid && (r_state != DONE);
    assign w_cnt_inc = {1'b0, r_count} + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOPE flits fall through every branch: accepted, but no effect.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_store     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_type == T_HEAD) begin
                        if (w_hd_ok) begin
                            w_latch     = 1'b1;
                            w_state_nxt = RECV;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (w_type == T_BODY || w_type == T_TAIL) begin
                        w_err = 1'b1;
                    end
                end
            end
            RECV: begin
                if (w_accept) begin
                    if (w_type == T_HEAD) begin
                        // The aborted packet and a bad new head share one error.
                        w_err = 1'b1;
                        if (w_hd_ok) w_latch     = 1'b1;
                        else         w_state_nxt = IDLE;
                    end else if (w_type == T_BODY) begin
                        if (w_cnt_inc < {1'b0, r_len}) begin
                            w_store = 1'b1;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end else if (w_type == T_TAIL) begin
                        if (w_cnt_inc == {1'b0, r_len}) begin
                            w_store     = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            DONE: begin
                if (bus.pkt_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_count <= '0;
            for (int k = 0; k < MAX_FLITS; k++) r_words[k] <= '0;
        end else begin
            if (w_latch) begin
                r_src   <= w_data[31:24];
                r_dst   <= w_data[23:16];
                r_id    <= w_data[15:8];
                r_len   <= w_hd_len;
                r_count <= '0;
            end else if (w_store) begin
                r_count <= w_cnt_inc[3:0];
            end
            for (int k = 0; k < MAX_FLITS; k++) begin
                if (w_latch)                          r_words[k] <= '0;
                else if (w_store && r_count == 4'(k)) r_words[k] <= w_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.flit_ready = (r_state != DONE);
    assign bus.pkt_valid  = (r_state == DONE);
    assign bus.pkt_src    = r_src;
    assign bus.pkt_dst    = r_dst;
    assign bus.pkt_id     = r_id;
    assign bus.pkt_len    = r_len;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_count  = r_err_count;

    for (genvar g = 0; g < MAX_FLITS; g++) begin : g_payload
        assign bus.pkt_payload[g*DATA_WIDTH +: DATA_WIDTH] = r_words[g];
    end
endmodule

// File: tb/tb_flit_reassembler.sv
// Directed and randomized bench for flit_reassembler against a packet-level reference model.
module tb_flit_reassembler;
    localparam int MF = 8;
    localparam int DW = 32;
    localparam int PW = MF * DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flit_reassembler_if #(.MAX_FLITS(MF), .DATA_WIDTH(DW)) bus();

    flit_reassembler #(.MAX_FLITS(MF), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = waiting for head, 1 = collecting, 2 = packet held.
    int          m_mode;
    logic [7:0]  m_src, m_dst, m_id;
    int          m_len, m_cnt, m_errcnt;
    logic [DW-1:0] m_words [MF];
    bit          m_errpulse;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] m_payload();
        logic [PW-1:0] p;
        for (int k = 0; k < MF; k++) p[k*DW +: DW] = m_words[k];
        return p;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_src = '0; m_dst = '0; m_id = '0;
        m_len = 0; m_cnt = 0; m_errcnt = 0; m_errpulse = 1'b0;
        for (int k = 0; k < MF; k++) m_words[k] = '0;
    endtask

    task automatic model_edge(input bit v, input logic [DW+1:0] f, input bit prdy, output bit acc);
        bit err;
        int l;
        err = 1'b0;
        acc = v && (m_mode != 2);
        if (acc) begin
            case (f[DW+1:DW])
                2'd0: begin
                    l = int'(f[7:4]);
                    if (m_mode == 1) err = 1'b1;
                    if (l >= 1 && l <= MF) begin
                        m_src = f[31:24]; m_dst = f[23:16]; m_id = f[15:8];
                        m_len = l; m_cnt = 0; m_mode = 1;
                        for (int k = 0; k < MF; k++) m_words[k] = '0;
                    end else begin
                        err = 1'b1; m_mode = 0;
                    end
                end
                2'd1: begin
                    if (m_mode == 0) err = 1'b1;
                    else if (m_cnt + 1 < m_len) begin
                        m_words[m_cnt] = f[DW-1:0]; m_cnt++;
                    end else begin
                        err = 1'b1; m_mode = 0;
                    end
                end
                2'd2: begin
                    if (m_mode == 0) err = 1'b1;
                    else if (m_cnt + 1 == m_len) begin
                        m_words[m_cnt] = f[DW-1:0]; m_cnt++; m_mode = 2;
                    end else begin
                        err = 1'b1; m_mode = 0;
                    end
                end
                default: ;
            endcase
        end else if (m_mode == 2 && prdy) begin
            m_mode = 0;
        end
        m_errpulse = err;
        if (err && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic check_outputs();
        chk("flit_ready", 64'(bus.flit_ready), 64'(m_mode != 2));
        chk("pkt_valid",  64'(bus.pkt_valid),  64'(m_mode == 2));
        chk("err_pulse",  64'(bus.err_pulse),  64'(m_errpulse));
        chk("err_count",  64'(bus.err_count),  64'(m_errcnt));
        if (m_mode == 2) begin
            chk("pkt_src", 64'(bus.pkt_src), 64'(m_src));
            chk("pkt_dst", 64'(bus.pkt_dst), 64'(m_dst));
            chk("pkt_id",  64'(bus.pkt_id),  64'(m_id));
            chk("pkt_len", 64'(bus.pkt_len), 64'(m_len));
            chk_wide("pkt_payload", bus.pkt_payload, m_payload());
        end
    endtask

    // Inputs change after the falling edge; outputs are compared on the next falling edge.
    task automatic step(input bit v, input logic [DW+1:0] f, input bit prdy, output bit acc);
        bus.flit_valid = v;
        bus.flit_in    = f;
        bus.pkt_ready  = prdy;
        model_edge(v, f, prdy, acc);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [DW+1:0] f, input bit prdy);
        bit a;
        step(1'b1, f, prdy, a);
    endtask

    function automatic logic [DW+1:0] head(input logic [7:0] s, input logic [7:0] d,
                                           input logic [7:0] i, input logic [3:0] l);
        return {2'b00, s, d, i, l, 4'h0};
    endfunction

    function automatic logic [DW+1:0] body(input logic [DW-1:0] d);
        return {2'b01, d};
    endfunction

    function automatic logic [DW+1:0] tail(input logic [DW-1:0] d);
        return {2'b10, d};
    endfunction

    // Reset is raised between clock edges to exercise its asynchronous path.
    task automatic do_reset();
        bus.flit_valid = 1'b0;
        bus.flit_in    = '0;
        bus.pkt_ready  = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_flit_ready", 64'(bus.flit_ready), 64'd1);
        chk("rst_pkt_valid",  64'(bus.pkt_valid),  64'd0);
        chk("rst_pkt_src",    64'(bus.pkt_src),    64'd0);
        chk("rst_pkt_dst",    64'(bus.pkt_dst),    64'd0);
        chk("rst_pkt_id",     64'(bus.pkt_id),     64'd0);
        chk("rst_pkt_len",    64'(bus.pkt_len),    64'd0);
        chk_wide("rst_payload", bus.pkt_payload, '0);
        chk("rst_err_pulse",  64'(bus.err_pulse),  64'd0);
        chk("rst_err_count",  64'(bus.err_count),  64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit a;
        bus.flit_valid = 1'b0;
        bus.flit_in    = '0;
        bus.pkt_ready  = 1'b0;
        model_reset();
        @(negedge clk);

        // Nominal three-flit packet.
        do_reset();
        send(head(8'h12, 8'h34, 8'h05, 4'd3), 1'b0);
        send(body(32'hA), 1'b0);
        send(body(32'hB), 1'b0);
        send(tail(32'hC), 1'b0);
        chk("nom_pkt_valid", 64'(bus.pkt_valid), 64'd1);
        chk("nom_pkt_len",   64'(bus.pkt_len),   64'd3);
        chk("nom_pkt_src",   64'(bus.pkt_src),   64'h12);
        chk("nom_pkt_dst",   64'(bus.pkt_dst),   64'h34);
        chk("nom_pkt_id",    64'(bus.pkt_id),    64'h05);
        chk_wide("nom_payload", bus.pkt_payload, PW'({32'hC, 32'hB, 32'hA}));
        chk("nom_err_count", 64'(bus.err_count), 64'd0);

        // Backpressure: a waiting head is refused while the packet is held.
        for (int i = 0; i < 5; i++) begin
            send(head(8'h01, 8'h02, 8'h03, 4'd1), 1'b0);
            chk("bp_flit_ready", 64'(bus.flit_ready), 64'd0);
        end
        step(1'b1, head(8'h01, 8'h02, 8'h03, 4'd1), 1'b1, a);
        chk("bp_release", 64'(bus.pkt_valid), 64'd0);
        step(1'b1, head(8'h01, 8'h02, 8'h03, 4'd1), 1'b0, a);
        chk("bp_head_accepted", 64'(a), 64'd1);
        send(tail(32'hD), 1'b0);
        chk("bp_second_valid", 64'(bus.pkt_valid), 64'd1);
        chk_wide("bp_second_payload", bus.pkt_payload, PW'(32'hD));
        step(1'b0, '0, 1'b1, a);

        // Early tail.
        do_reset();
        send(head(8'h21, 8'h22, 8'h23, 4'd4), 1'b0);
        send(body(32'h1), 1'b0);
        send(tail(32'h2), 1'b0);
        chk("early_err_pulse", 64'(bus.err_pulse), 64'd1);
        chk("early_err_count", 64'(bus.err_count), 64'd1);
        step(1'b0, '0, 1'b0, a);
        chk("early_pulse_drop", 64'(bus.err_pulse), 64'd0);
        chk("early_pkt_valid",  64'(bus.pkt_valid), 64'd0);

        // Head arriving mid-packet.
        do_reset();
        send(head(8'h31, 8'h32, 8'h33, 4'd2), 1'b0);
        send(body(32'h1), 1'b0);
        send(head(8'h41, 8'h42, 8'h43, 4'd1), 1'b0);
        send(tail(32'hF), 1'b0);
        chk("hir_err_count", 64'(bus.err_count), 64'd1);
        chk("hir_pkt_len",   64'(bus.pkt_len),   64'd1);
        chk_wide("hir_payload", bus.pkt_payload, PW'(32'hF));
        step(1'b0, '0, 1'b1, a);

        // Stray and malformed flits, then saturation.
        do_reset();
        send(body(32'h5), 1'b0);
        send(head(8'h1, 8'h2, 8'h3, 4'd0), 1'b0);
        send(head(8'h1, 8'h2, 8'h3, 4'd9), 1'b0);
        chk("stray_err_count", 64'(bus.err_count), 64'd3);
        for (int i = 0; i < 260; i++) send(body(32'(i)), 1'b0);
        chk("sat_err_count", 64'(bus.err_count), 64'd255);

        // Reset in the middle of a packet.
        do_reset();
        send(head(8'h51, 8'h52, 8'h53, 4'd2), 1'b0);
        send(body(32'h99), 1'b0);
        do_reset();
        send(head(8'h61, 8'h62, 8'h63, 4'd1), 1'b0);
        send(tail(32'h77), 1'b0);
        chk("rmp_pkt_valid", 64'(bus.pkt_valid), 64'd1);
        chk_wide("rmp_payload", bus.pkt_payload, PW'(32'h77));
        chk("rmp_err_count", 64'(bus.err_count), 64'd0);
        step(1'b0, '0, 1'b1, a);

        // Randomized packets with gaps, corruption, NOPEs and backpressure.
        do_reset();
        for (int p = 0; p < 300; p++) begin
            logic [DW+1:0] q[$];
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, MF);
            q.push_back(head(8'($urandom), 8'($urandom), 8'($urandom), 4'(len)));
            for (int i = 0; i < len - 1; i++) q.push_back(body($urandom));
            if (len >= 1) q.push_back(tail($urandom));
            foreach (q[j]) begin
                logic [DW+1:0] f;
                int guard;
                f = q[j];
                if ($urandom_range(0, 14) == 0) f[DW+1:DW] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) send({2'b11, 32'($urandom)}, 1'($urandom));
                a = 1'b0;
                guard = 0;
                while (!a && guard < 50) begin
                    step(1'($urandom_range(0, 3) != 0), f, (guard > 20) ? 1'b1 : 1'($urandom), a);
                    guard++;
                end
                chk("rand_flit_taken", 64'(a), 64'd1);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
